// File: rtl/prescaler_pkg.sv
// -----------------------------------------------------------------------------
// prescaler_pkg
// Shared encodings for the modulo-N prescaler.
//   mode_e  : output-mode encoding as seen on the MODE input pins
//   MIN_DIV : smallest divisor the counter accepts; smaller requests clamp to it
// -----------------------------------------------------------------------------
package prescaler_pkg;

    typedef enum logic [1:0] {
        MODE_PULSE     = 2'b00,
        MODE_SQUARE    = 2'b01,
        MODE_ONESHOT   = 2'b10,
        MODE_PULSE_ALT = 2'b11   // behaves as pulse; folded to MODE_PULSE on apply
    } mode_e;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/mod_n_core.sv
// -----------------------------------------------------------------------------
// mod_n_core
// Count register with wrap detection plus the one-shot busy flag.
// State changes on the falling clock edge.
//   clk       in   clock (falling edge active)
//   clear     in   asynchronous active-low reset
//   en        in   1 = count, 0 = hold Count at 0 and drop busy
//   oneshot   in   active mode is one-shot: count only while busy
//   arm       in   one-shot start strobe (ignored while busy)
//   div       in   active divisor, always >= 2
//   count     out  registered count, 0..div-1
//   count_nxt out  value count takes at the next edge
//   busy      out  one-shot run in progress
//   wrap      out  current cycle is the last of a period and counting
// -----------------------------------------------------------------------------
module mod_n_core #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             oneshot,
    input  logic             arm,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt,
    output logic             busy,
    output logic             wrap
);

    logic counting;
    logic busy_nxt;

    always_comb begin
        counting  = en && (!oneshot || busy);
        wrap      = counting && (count == div - WIDTH'(1));
        count_nxt = count;
        busy_nxt  = busy;
        if (!en) begin
            count_nxt = '0;
            busy_nxt  = 1'b0;
        end else if (wrap) begin
            count_nxt = '0;
            busy_nxt  = 1'b0;
        end else if (counting) begin
            count_nxt = count + WIDTH'(1);
        end else if (oneshot && arm) begin
            // ARM edge only raises busy; Count is 0 for that first cycle of the run
            busy_nxt = 1'b1;
        end
        if (!oneshot) begin
            busy_nxt = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= count_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: rtl/mod_n_prescaler.sv
// -----------------------------------------------------------------------------
// mod_n_prescaler
// Runtime-programmable modulo-N prescaler with pulse, square and one-shot
// outputs and a saturating count of completed periods. All state updates on
// the falling clock edge.
//   clk       in   clock (falling edge active)
//   clear     in   asynchronous active-low reset
//   en        in   1 = count, 0 = halt (every halted edge applies pending config)
//   div_in    in   new divisor, captured when load=1 (values < 2 become 2)
//   load      in   divisor capture strobe
//   mode      in   00 pulse, 01 square, 10 one-shot, 11 pulse
//   arm       in   one-shot start strobe
//   clr_evt   in   synchronous clear of periods (wins over an increment)
//   count     out  current count, 0..div-1
//   out       out  divided output, registered and aligned with count
//   load_ack  out  one-cycle pulse when a loaded divisor becomes active
//   busy      out  one-shot in progress
//   periods   out  completed periods, saturating at all-ones
// -----------------------------------------------------------------------------
module mod_n_prescaler
    import prescaler_pkg::*;
#(
    parameter int WIDTH       = 7,
    parameter int DEFAULT_DIV = 100,
    parameter int EVT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 en,
    input  logic [WIDTH-1:0]     div_in,
    input  logic                 load,
    input  logic [1:0]           mode,
    input  logic                 arm,
    input  logic                 clr_evt,
    output logic [WIDTH-1:0]     count,
    output logic                 out,
    output logic                 load_ack,
    output logic                 busy,
    output logic [EVT_WIDTH-1:0] periods
);

    localparam logic [WIDTH-1:0]     DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [EVT_WIDTH-1:0] EVT_MAX = '1;

    logic [WIDTH-1:0]     div_act, div_pend, div_nxt, div_pend_nxt, div_in_clamped;
    logic                 load_pend, load_pend_nxt, load_ack_nxt;
    mode_e                mode_act, mode_req, mode_nxt;
    logic                 sq, sq_nxt, out_nxt;
    logic                 apply;
    logic                 wrap;
    logic [WIDTH-1:0]     count_nxt;
    logic [EVT_WIDTH-1:0] periods_nxt;

    mod_n_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .clear     (clear),
        .en        (en),
        .oneshot   (mode_act == MODE_ONESHOT),
        .arm       (arm),
        .div       (div_act),
        .count     (count),
        .count_nxt (count_nxt),
        .busy      (busy),
        .wrap      (wrap)
    );

    // Configuration: divisor and mode only change at a period boundary or while
    // halted, so a running period never sees a new divisor.
    always_comb begin
        div_in_clamped = (div_in < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_in;
        mode_req       = (mode == MODE_PULSE_ALT) ? MODE_PULSE : mode_e'(mode);
        apply          = wrap || !en;
        div_nxt        = div_act;
        div_pend_nxt   = div_pend;
        load_pend_nxt  = load_pend;
        mode_nxt       = mode_act;
        load_ack_nxt   = 1'b0;
        if (apply) begin
            // A load coinciding with the apply point bypasses the pending register
            div_nxt       = load ? div_in_clamped : div_pend;
            div_pend_nxt  = div_nxt;
            mode_nxt      = mode_req;
            load_ack_nxt  = load || load_pend;
            load_pend_nxt = 1'b0;
        end else if (load) begin
            div_pend_nxt  = div_in_clamped;
            load_pend_nxt = 1'b1;
        end
    end

    // Output: computed from next-state values so the registered out lines up
    // with the registered count in the same cycle.
    always_comb begin
        if (!en || mode_nxt != MODE_SQUARE || mode_act != MODE_SQUARE) begin
            sq_nxt = 1'b0;   // halted, leaving, or just entering square mode
        end else if (wrap) begin
            sq_nxt = !sq;
        end else begin
            sq_nxt = sq;
        end
        if (!en) begin
            out_nxt = 1'b0;
        end else if (mode_nxt == MODE_SQUARE) begin
            out_nxt = sq_nxt;
        end else begin
            out_nxt = (count_nxt == div_nxt - WIDTH'(1));
        end
    end

    always_comb begin
        if (clr_evt) begin
            periods_nxt = '0;
        end else if (wrap && periods != EVT_MAX) begin
            periods_nxt = periods + EVT_WIDTH'(1);
        end else begin
            periods_nxt = periods;
        end
    end

    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            div_act   <= DIV_RST;
            div_pend  <= DIV_RST;
            load_pend <= 1'b0;
            load_ack  <= 1'b0;
            mode_act  <= MODE_PULSE;
            sq        <= 1'b0;
            out       <= 1'b0;
            periods   <= '0;
        end else begin
            div_act   <= div_nxt;
            div_pend  <= div_pend_nxt;
            load_pend <= load_pend_nxt;
            load_ack  <= load_ack_nxt;
            mode_act  <= mode_nxt;
            sq        <= sq_nxt;
            out       <= out_nxt;
            periods   <= periods_nxt;
        end
    end

endmodule

// File: tb/tb_mod_n_prescaler.sv
// -----------------------------------------------------------------------------
// tb_mod_n_prescaler
// Directed bench for mod_n_prescaler. Inputs change just after the rising
// edge; the DUT updates on the falling edge; outputs are sampled on the next
// rising edge. Each step pushes the hand-derived expected output snapshot
// {count, out, load_ack, busy, periods}; the monitor pops one per rising edge.
// -----------------------------------------------------------------------------
module tb_mod_n_prescaler;

    localparam int W = 18;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic [6:0] div_in = '0;
    logic       load = 1'b0;
    logic [1:0] mode = '0;
    logic       arm = 1'b0;
    logic       clr_evt = 1'b0;
    logic [6:0] count;
    logic       out;
    logic       load_ack;
    logic       busy;
    logic [7:0] periods;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;

    mod_n_prescaler #(.WIDTH(7), .DEFAULT_DIV(100), .EVT_WIDTH(8)) dut (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .div_in   (div_in),
        .load     (load),
        .mode     (mode),
        .arm      (arm),
        .clr_evt  (clr_evt),
        .count    (count),
        .out      (out),
        .load_ack (load_ack),
        .busy     (busy),
        .periods  (periods)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // driver: apply one cycle of inputs and queue the expected state after the next falling edge
    task automatic step(input string t, input int cl, input int e, input int ld, input int d,
                        input int m, input int a, input int ce,
                        input int ec, input int eo, input int ea, input int eb, input int ep);
        @(posedge clk);
        #1;
        clear   = (cl != 0);
        en      = (e != 0);
        load    = (ld != 0);
        div_in  = 7'(d);
        mode    = 2'(m);
        arm     = (a != 0);
        clr_evt = (ce != 0);
        exp_q.push_back({7'(ec), (eo != 0), (ea != 0), (eb != 0), 8'(ep)});
        tag_q.push_back(t);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        tag;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = tag_q.pop_front();
                act_v = {count, out, load_ack, busy, periods};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got count=%0d out=%0b load_ack=%0b busy=%0b periods=%0d, expected count=%0d out=%0b load_ack=%0b busy=%0b periods=%0d",
                             tag, act_v[17:11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                             exp_v[17:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        int c;
        int p;

        // reset held, then released while halted
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset_release", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // default divide-by-100 pulse
        for (int k = 1; k <= 100; k++) begin
            c = k % 100;
            step("pulse100", 1, 1, 0, 0, 0, 0, 0, c, (c == 99) ? 1 : 0, 0, 0, k / 100);
        end

        // loads at count 29 (20) and count 40 (10): last wins, applied at the wrap
        for (int k = 101; k <= 200; k++) begin
            c = k % 100;
            step("load_midperiod", 1, 1, (k == 130 || k == 141) ? 1 : 0, (k == 130) ? 20 : 10, 0, 0, 0,
                 c, (c == 99) ? 1 : 0, (k == 200) ? 1 : 0, 0, k / 100);
        end
        for (int j = 1; j <= 30; j++) begin
            c = j % 10;
            step("pulse10", 1, 1, 0, 0, 0, 0, 0, c, (c == 9) ? 1 : 0, 0, 0, 2 + j / 10);
        end

        // divisor 1 clamps to 2, applied on the halted edge
        step("load_clamp", 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 5);
        for (int j = 1; j <= 6; j++) begin
            c = j % 2;
            step("pulse2", 1, 1, 0, 0, 0, 0, 0, c, (c == 1) ? 1 : 0, 0, 0, 5 + j / 2);
        end

        // square mode, divisor 5
        step("load_square", 1, 0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 8);
        for (int j = 1; j <= 20; j++) begin
            step("square5", 1, 1, 0, 0, 1, 0, 0, j % 5, (j / 5) % 2, 0, 0, 8 + j / 5);
        end

        // one-shot, divisor 4; second ARM while busy is ignored
        step("load_oneshot", 1, 0, 1, 4, 2, 0, 0, 0, 0, 1, 0, 12);
        step("oneshot_idle", 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 12);
        step("oneshot_idle", 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 12);
        step("oneshot_arm", 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 12);
        for (int j = 1; j <= 3; j++) begin
            step("oneshot_run", 1, 1, 0, 0, 2, (j == 2) ? 1 : 0, 0, j, (j == 3) ? 1 : 0, 0, 1, 12);
        end
        step("oneshot_end", 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 13);
        for (int j = 0; j < 3; j++) begin
            step("oneshot_after", 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 13);
        end

        // back to divide-by-100 pulse, clear at count 57 with a load of 10 outstanding
        step("load_100", 1, 0, 1, 100, 0, 0, 0, 0, 0, 1, 0, 13);
        for (int j = 1; j <= 57; j++) begin
            step("pre_clear", 1, 1, (j == 20) ? 1 : 0, 10, 0, 0, 0, j, 0, 0, 0, 13);
        end
        step("async_clear", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 100; j++) begin
            c = j % 100;
            step("post_clear100", 1, 1, 0, 0, 0, 0, 0, c, (c == 99) ? 1 : 0, 0, 0, j / 100);
        end

        // saturation with divisor 2, then clr_evt on a wrap edge
        step("load_sat", 1, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int j = 1; j <= 604; j++) begin
            c = j % 2;
            if (j <= 600)      p = (1 + j / 2 > 255) ? 255 : 1 + j / 2;
            else if (j == 601) p = 255;
            else if (j <= 603) p = 0;
            else               p = 1;
            step((j == 602) ? "clr_evt_wrap" : "saturate", 1, 1, 0, 0, 0, 0, (j == 602) ? 1 : 0,
                 c, (c == 1) ? 1 : 0, 0, 0, p);
        end
        step("en_low_mid", 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        step("en_low_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // drain
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
